// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared state encoding, error codes and constants for the UART
//            command-frame parser.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int c_ST_W = 3;

    localparam logic [c_ST_W-1:0] c_ST_IDLE    = 3'd0;
    localparam logic [c_ST_W-1:0] c_ST_ADDR    = 3'd1;
    localparam logic [c_ST_W-1:0] c_ST_LEN     = 3'd2;
    localparam logic [c_ST_W-1:0] c_ST_PAYLOAD = 3'd3;
    localparam logic [c_ST_W-1:0] c_ST_CSUM    = 3'd4;
    localparam logic [c_ST_W-1:0] c_ST_COMMIT  = 3'd5;

    localparam logic [1:0] c_ERR_NONE     = 2'b00;
    localparam logic [1:0] c_ERR_BAD_LEN  = 2'b01;
    localparam logic [1:0] c_ERR_BAD_CSUM = 2'b10;
    localparam logic [1:0] c_ERR_TIMEOUT  = 2'b11;

    localparam logic [7:0] c_SYNC_BYTE_DEFAULT = 8'hA5;

    function automatic logic len_valid(input logic [7:0] len, input int max_len);
        return (len != 8'd0) && (int'(len) <= max_len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_buf.sv
`default_nettype none
// ============================================================================
// Module   : cmd_buf
// Purpose  : Payload storage, one write port and one registered read port.
// Revision : 1.0  initial release
// ============================================================================
module cmd_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 8'h00;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_parser
// Purpose  : Parses SYNC/ADDR/LEN/payload/CSUM frames from a UART byte stream
//            and replays the payload as register-bank writes.
// Revision : 1.0  initial release
// ============================================================================
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE      = uart_pkg::c_SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         MAX_LEN        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       wr_ready,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       rx_drop,
    output logic       busy
);
    import uart_pkg::*;

    localparam int              c_AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int              c_TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TO_LIMIT = c_TW'(TIMEOUT_CYCLES);

    logic [c_ST_W-1:0] r_state;
    logic [7:0]        r_base;
    logic [7:0]        r_len;
    logic [7:0]        r_idx;
    logic [7:0]        r_sum;
    logic [c_TW-1:0]   r_to_cnt;
    logic              r_wr_en;
    logic [7:0]        r_wr_addr;
    logic              r_frame_ok;
    logic              r_frame_err;
    logic [1:0]        r_err_code;
    logic              r_rx_drop;

    logic              w_accept;
    logic              w_last_beat;
    logic              w_timed;
    logic [c_TW-1:0]   w_to_cnt_inc;
    logic              w_to_hit;
    logic [7:0]        w_sum_next;
    logic              w_buf_we;
    logic [c_AW-1:0]   w_rd_idx;
    logic [7:0]        w_buf_rdata;

    assign w_accept     = r_wr_en & wr_ready;
    assign w_last_beat  = (r_idx == (r_len - 8'd1));
    assign w_timed      = (r_state == c_ST_ADDR) || (r_state == c_ST_LEN) ||
                          (r_state == c_ST_PAYLOAD) || (r_state == c_ST_CSUM);
    assign w_to_cnt_inc = r_to_cnt + 1'b1;
    assign w_to_hit     = w_timed && !rx_valid && (w_to_cnt_inc == c_TO_LIMIT);
    assign w_sum_next   = r_sum + rx_data;
    assign w_buf_we     = (r_state == c_ST_PAYLOAD) && rx_valid;

    // Read one beat ahead on acceptance so the next beat's data lands with the
    // address update; while stalled the same entry is re-read every cycle.
    assign w_rd_idx = (r_state != c_ST_COMMIT) ? '0 :
                      w_accept ? (r_idx[c_AW-1:0] + 1'b1) : r_idx[c_AW-1:0];

    cmd_buf #(
        .DEPTH (MAX_LEN),
        .AW    (c_AW)
    ) u_cmd_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_buf_we),
        .i_waddr (r_idx[c_AW-1:0]),
        .i_wdata (rx_data),
        .i_raddr (w_rd_idx),
        .o_rdata (w_buf_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_base      <= 8'h00;
            r_len       <= 8'h00;
            r_idx       <= 8'h00;
            r_sum       <= 8'h00;
            r_to_cnt    <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= 8'h00;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= c_ERR_NONE;
            r_rx_drop   <= 1'b0;
        end else begin
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= c_ERR_NONE;
            r_rx_drop   <= 1'b0;

            if (!w_timed || rx_valid) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= w_to_cnt_inc;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        r_state <= c_ST_ADDR;
                    end
                end
                c_ST_ADDR: begin
                    if (rx_valid) begin
                        r_base  <= rx_data;
                        r_sum   <= rx_data;
                        r_state <= c_ST_LEN;
                    end
                end
                c_ST_LEN: begin
                    if (rx_valid) begin
                        r_len <= rx_data;
                        r_sum <= w_sum_next;
                        r_idx <= 8'h00;
                        if (len_valid(rx_data, MAX_LEN)) begin
                            r_state <= c_ST_PAYLOAD;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= c_ERR_BAD_LEN;
                            r_state     <= c_ST_IDLE;
                        end
                    end
                end
                c_ST_PAYLOAD: begin
                    if (rx_valid) begin
                        r_sum <= w_sum_next;
                        r_idx <= r_idx + 8'd1;
                        if (w_last_beat) begin
                            r_state <= c_ST_CSUM;
                        end
                    end
                end
                c_ST_CSUM: begin
                    if (rx_valid) begin
                        if (w_sum_next == 8'h00) begin
                            r_idx     <= 8'h00;
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_base;
                            r_state   <= c_ST_COMMIT;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= c_ERR_BAD_CSUM;
                            r_state     <= c_ST_IDLE;
                        end
                    end
                end
                c_ST_COMMIT: begin
                    if (rx_valid) begin
                        r_rx_drop <= 1'b1;
                    end
                    if (w_accept) begin
                        if (w_last_beat) begin
                            r_wr_en    <= 1'b0;
                            r_frame_ok <= 1'b1;
                            r_state    <= c_ST_IDLE;
                        end else begin
                            r_idx     <= r_idx + 8'd1;
                            r_wr_addr <= r_wr_addr + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase

            // Only reachable without rx_valid, so an arriving byte always wins.
            if (w_to_hit) begin
                r_frame_err <= 1'b1;
                r_err_code  <= c_ERR_TIMEOUT;
                r_state     <= c_ST_IDLE;
            end
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = w_buf_rdata;
    assign frame_ok  = r_frame_ok;
    assign frame_err = r_frame_err;
    assign err_code  = r_err_code;
    assign rx_drop   = r_rx_drop;
    assign busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_parser
// Purpose  : Directed self-checking bench for uart_cmd_parser with a write
//            scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_cmd_parser;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic       wr_ready = 1'b0;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       rx_drop;
    logic       busy;

    uart_cmd_parser #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (50),
        .MAX_LEN        (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .wr_ready  (wr_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .rx_drop   (rx_drop),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  tx[$];
    int          n_ok = 0, n_err = 0, n_wr = 0, n_wren = 0, n_drop = 0;
    int          cyc_no = 0, first_wr = -1, last_wr = -1, ok_cyc = -1;
    logic [1:0]  last_code = 2'b00;
    logic        stalled = 1'b0;
    logic [15:0] stall_beat = 16'h0;
    int          ok0, err0, wr0, wren0, drop0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        logic [15:0] e;
        cyc_no++;
        if (frame_ok) begin
            n_ok++;
            ok_cyc = cyc_no;
        end
        if (frame_err) begin
            n_err++;
            last_code = err_code;
        end else begin
            check("err_code_quiet", {30'd0, err_code}, 32'd0);
        end
        if (rx_drop) n_drop++;
        if (wr_en) n_wren++;
        if (stalled) check("stall_hold", {15'd0, wr_en, wr_addr, wr_data}, {15'd0, 1'b1, stall_beat});
        stalled    = wr_en && !wr_ready;
        stall_beat = {wr_addr, wr_data};
        if (wr_en && wr_ready) begin
            n_wr++;
            if (first_wr < 0) first_wr = cyc_no;
            last_wr = cyc_no;
            check("write_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("write_beat", {16'd0, wr_addr, wr_data}, {16'd0, e});
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic rdy);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        wr_ready = rdy;
        monitor();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, rdy);
    endtask

    task automatic send_tx(input logic rdy);
        foreach (tx[i]) cyc(1'b1, tx[i], rdy);
    endtask

    task automatic snap();
        ok0 = n_ok; err0 = n_err; wr0 = n_wr; wren0 = n_wren; drop0 = n_drop;
        first_wr = -1; last_wr = -1;
    endtask

    // Arithmetic-progression payload; expected writes and checksum from the bench model.
    task automatic build_frame(input logic [7:0] addr, input int len,
                               input logic [7:0] seed, input logic [7:0] step);
        logic [7:0] sum;
        logic [7:0] d;
        tx.delete();
        tx.push_back(8'hA5);
        tx.push_back(addr);
        tx.push_back(8'(len));
        sum = addr + 8'(len);
        d   = seed;
        for (int i = 0; i < len; i++) begin
            tx.push_back(d);
            sum = sum + d;
            exp_q.push_back({8'(addr + 8'(i)), d});
            d = d + step;
        end
        tx.push_back(8'h00 - sum);
    endtask

    initial begin
        #1;
        check("rst_wr_en",     {31'd0, wr_en},     32'd0);
        check("rst_frame_ok",  {31'd0, frame_ok},  32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_rx_drop",   {31'd0, rx_drop},   32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_err_code",  {30'd0, err_code},  32'd0);
        check("rst_wr_addr",   {24'd0, wr_addr},   32'd0);
        check("rst_wr_data",   {24'd0, wr_data},   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic two-byte frame, back-to-back writes
        snap();
        build_frame(8'h10, 2, 8'h11, 8'h11);
        check("t1_csum_byte", {24'd0, tx[5]}, 32'hBB);
        send_tx(1'b1);
        idle(6, 1'b1);
        check("t1_writes", n_wr - wr0, 2);
        check("t1_ok", n_ok - ok0, 1);
        check("t1_err", n_err - err0, 0);
        check("t1_back_to_back", last_wr - first_wr, 1);
        check("t1_queue_empty", exp_q.size(), 0);
        check("t1_idle", {31'd0, busy}, 32'd0);

        // Address wrap
        snap();
        build_frame(8'hFF, 2, 8'h01, 8'h01);
        send_tx(1'b1);
        idle(6, 1'b1);
        check("t2_writes", n_wr - wr0, 2);
        check("t2_ok", n_ok - ok0, 1);
        check("t2_queue_empty", exp_q.size(), 0);

        // Bad checksum
        snap();
        tx = {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h00};
        send_tx(1'b1);
        idle(5, 1'b1);
        check("t3_err", n_err - err0, 1);
        check("t3_code", {30'd0, last_code}, 32'd2);
        check("t3_no_wr_en", n_wren - wren0, 0);
        check("t3_no_ok", n_ok - ok0, 0);

        // Junk in IDLE ignored, then zero length
        snap();
        tx = {8'h3C, 8'h00, 8'hA5, 8'h10, 8'h00};
        send_tx(1'b1);
        idle(3, 1'b1);
        check("t4a_err", n_err - err0, 1);
        check("t4a_code", {30'd0, last_code}, 32'd1);
        check("t4a_idle", {31'd0, busy}, 32'd0);
        snap();
        tx = {8'hA5, 8'h10, 8'h11};
        send_tx(1'b1);
        idle(3, 1'b1);
        check("t4b_err", n_err - err0, 1);
        check("t4b_code", {30'd0, last_code}, 32'd1);
        check("t4b_idle", {31'd0, busy}, 32'd0);

        // Maximum length frame
        snap();
        build_frame(8'h20, 16, 8'h40, 8'h01);
        send_tx(1'b1);
        idle(20, 1'b1);
        check("t5_writes", n_wr - wr0, 16);
        check("t5_ok", n_ok - ok0, 1);
        check("t5_err", n_err - err0, 0);
        check("t5_queue_empty", exp_q.size(), 0);

        // Timeout after silence of TIMEOUT_CYCLES
        snap();
        tx = {8'hA5, 8'h10};
        send_tx(1'b1);
        idle(49, 1'b1);
        check("t6_no_early_to", n_err - err0, 0);
        idle(3, 1'b1);
        check("t6_to_err", n_err - err0, 1);
        check("t6_to_code", {30'd0, last_code}, 32'd3);
        check("t6_to_idle", {31'd0, busy}, 32'd0);
        idle(60, 1'b1);
        check("t6_no_idle_to", n_err - err0, 1);

        // Byte exactly at the timeout boundary wins
        snap();
        tx = {8'hA5, 8'h10};
        send_tx(1'b1);
        idle(49, 1'b1);
        exp_q.push_back({8'h10, 8'h33});
        tx = {8'h01, 8'h33, 8'hBC};
        send_tx(1'b1);
        idle(5, 1'b1);
        check("t7_err", n_err - err0, 0);
        check("t7_ok", n_ok - ok0, 1);
        check("t7_writes", n_wr - wr0, 1);

        // Stalled commit with drops; sync byte as payload data
        snap();
        tx = {8'hA5, 8'h80, 8'h04, 8'hA5, 8'h01, 8'h02, 8'h03, 8'hD1};
        exp_q.push_back({8'h80, 8'hA5});
        exp_q.push_back({8'h81, 8'h01});
        exp_q.push_back({8'h82, 8'h02});
        exp_q.push_back({8'h83, 8'h03});
        send_tx(1'b0);
        idle(60, 1'b0);
        check("t8_commit_no_to", n_err - err0, 0);
        cyc(1'b1, 8'h77, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'hA5, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        idle(4, 1'b1);
        check("t8_writes", n_wr - wr0, 4);
        check("t8_ok", n_ok - ok0, 1);
        check("t8_ok_timing", ok_cyc - last_wr, 1);
        check("t8_drops", n_drop - drop0, 2);
        check("t8_err", n_err - err0, 0);
        check("t8_queue_empty", exp_q.size(), 0);
        check("t8_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of a stalled commit
        snap();
        tx = {8'hA5, 8'h40, 8'h02, 8'h01, 8'h02, 8'hBB};
        send_tx(1'b0);
        idle(3, 1'b0);
        check("t9_in_commit", {31'd0, wr_en}, 32'd1);
        #2;
        rst_n   = 1'b0;
        stalled = 1'b0;
        #1;
        check("t9_rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("t9_rst_busy", {31'd0, busy}, 32'd0);
        check("t9_rst_wr_addr", {24'd0, wr_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        snap();
        build_frame(8'h10, 2, 8'h11, 8'h11);
        send_tx(1'b1);
        idle(6, 1'b1);
        check("t9_recover_writes", n_wr - wr0, 2);
        check("t9_recover_ok", n_ok - ok0, 1);
        check("t9_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
